// File: rtl/mem_io_stage_if.sv
// EX->MEM request bus, MEM->WB writeback result and the external I/O port handshakes.
// The stage itself connects through the slave modport.
interface mem_io_stage_if;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] mem_addr_i;
   logic        memR_i;
   logic        memW_i;
   logic        in_i;
   logic        out_i;
   logic        stall_req;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        addr_err;
   logic        io_in_valid;
   logic        io_in_ready;
   logic [31:0] io_in_data;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [31:0] io_out_data;

   modport master (
      output wd_i, wreg_i, wdata_i, mem_addr_i, memR_i, memW_i, in_i, out_i,
      output io_in_valid, io_in_data, io_out_ready,
      input  stall_req, wd_o, wreg_o, wdata_o, addr_err,
      input  io_in_ready, io_out_valid, io_out_data
   );

   modport slave (
      input  wd_i, wreg_i, wdata_i, mem_addr_i, memR_i, memW_i, in_i, out_i,
      input  io_in_valid, io_in_data, io_out_ready,
      output stall_req, wd_o, wreg_o, wdata_o, addr_err,
      output io_in_ready, io_out_valid, io_out_data
   );
endinterface

// File: rtl/mem_io_stage.sv
// Memory/IO pipeline stage: data RAM loads/stores, input/output port handshakes,
// upstream stall generation and the registered writeback result.
module mem_io_stage #(
   parameter int ADDR_W = 10
) (
   input  logic           clk,
   input  logic           rst,
   mem_io_stage_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, IN_WAIT, OUT_WAIT} state_t;

   state_t      state_reg;
   logic [4:0]  wd_reg;
   logic        wreg_reg;
   logic [31:0] wdata_reg;
   logic        addr_err_reg;
   logic        io_in_ready_reg;
   logic        io_out_valid_reg;
   logic [31:0] io_out_data_reg;

   logic [31:0] ram [2**ADDR_W];
   logic [31:0] ram_rdata_reg;

   logic              addr_bad;
   logic [ADDR_W-1:0] word_index;
   logic              ram_we;
   logic              ram_re;
   logic              stall_next;

   assign addr_bad   = (|bus.mem_addr_i[1:0]) || (|bus.mem_addr_i[31:ADDR_W+2]);
   assign word_index = bus.mem_addr_i[ADDR_W+1:2];

   // memR outranks memW, so a store only fires when no load is requested.
   assign ram_re = (state_reg == IDLE) && bus.memR_i && !addr_bad;
   assign ram_we = (state_reg == IDLE) && !bus.memR_i && bus.memW_i && !addr_bad;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[word_index] <= bus.wdata_i;
      end
      if (ram_re) begin
         ram_rdata_reg <= ram[word_index];
      end
   end

   always_comb begin
      stall_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.memR_i) begin
               stall_next = !addr_bad;
            end else if (bus.memW_i) begin
               stall_next = 1'b0;
            end else if (bus.in_i || bus.out_i) begin
               stall_next = 1'b1;
            end
         end
         LOAD:     stall_next = 1'b0;
         IN_WAIT:  stall_next = !bus.io_in_valid;
         OUT_WAIT: stall_next = !bus.io_out_ready;
         default:  stall_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         wd_reg           <= '0;
         wreg_reg         <= 1'b0;
         wdata_reg        <= '0;
         addr_err_reg     <= 1'b0;
         io_in_ready_reg  <= 1'b0;
         io_out_valid_reg <= 1'b0;
         io_out_data_reg  <= '0;
      end else begin
         addr_err_reg <= 1'b0;
         // Bubble by default; each branch overrides with real writeback data.
         wd_reg    <= '0;
         wreg_reg  <= 1'b0;
         wdata_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (bus.memR_i || bus.memW_i) begin
                  if (addr_bad) begin
                     addr_err_reg <= 1'b1;
                  end else if (bus.memR_i) begin
                     state_reg <= LOAD;
                  end else begin
                     wd_reg    <= bus.wd_i;
                     wreg_reg  <= bus.wreg_i;
                     wdata_reg <= bus.wdata_i;
                  end
               end else if (bus.in_i) begin
                  io_in_ready_reg <= 1'b1;
                  state_reg       <= IN_WAIT;
               end else if (bus.out_i) begin
                  io_out_data_reg  <= bus.wdata_i;
                  io_out_valid_reg <= 1'b1;
                  state_reg        <= OUT_WAIT;
               end else begin
                  wd_reg    <= bus.wd_i;
                  wreg_reg  <= bus.wreg_i;
                  wdata_reg <= bus.wdata_i;
               end
            end
            LOAD: begin
               wd_reg    <= bus.wd_i;
               wreg_reg  <= bus.wreg_i;
               wdata_reg <= ram_rdata_reg;
               state_reg <= IDLE;
            end
            IN_WAIT: begin
               if (bus.io_in_valid) begin
                  wd_reg          <= bus.wd_i;
                  wreg_reg        <= bus.wreg_i;
                  wdata_reg       <= bus.io_in_data;
                  io_in_ready_reg <= 1'b0;
                  state_reg       <= IDLE;
               end
            end
            OUT_WAIT: begin
               if (bus.io_out_ready) begin
                  wd_reg           <= bus.wd_i;
                  wreg_reg         <= bus.wreg_i;
                  wdata_reg        <= bus.wdata_i;
                  io_out_valid_reg <= 1'b0;
                  state_reg        <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.stall_req    = stall_next;
   assign bus.wd_o         = wd_reg;
   assign bus.wreg_o       = wreg_reg;
   assign bus.wdata_o      = wdata_reg;
   assign bus.addr_err     = addr_err_reg;
   assign bus.io_in_ready  = io_in_ready_reg;
   assign bus.io_out_valid = io_out_valid_reg;
   assign bus.io_out_data  = io_out_data_reg;
endmodule

// File: tb/tb_mem_io_stage.sv
// Directed bench for mem_io_stage: ALU pass-through, store/load, bad addresses,
// port-in/port-out handshakes and reset during an output wait.
module tb_mem_io_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   mem_io_stage_if bus ();

   mem_io_stage #(.ADDR_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      bus.memR_i = 1'b0;
      bus.memW_i = 1'b0;
      bus.in_i   = 1'b0;
      bus.out_i  = 1'b0;
   endtask

   task automatic set_op(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] addr);
      bus.wd_i       = wd;
      bus.wreg_i     = wreg;
      bus.wdata_i    = wdata;
      bus.mem_addr_i = addr;
   endtask

   initial begin
      clear_req();
      set_op(5'd0, 1'b0, 32'h0, 32'h0);
      bus.io_in_valid  = 1'b0;
      bus.io_in_data   = 32'h0;
      bus.io_out_ready = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_wd", {27'd0, bus.wd_o}, 32'd0);
      chk("rst_wreg", {31'd0, bus.wreg_o}, 32'd0);
      chk("rst_wdata", bus.wdata_o, 32'd0);
      chk("rst_err", {31'd0, bus.addr_err}, 32'd0);
      chk("rst_inrdy", {31'd0, bus.io_in_ready}, 32'd0);
      chk("rst_outvld", {31'd0, bus.io_out_valid}, 32'd0);
      chk("rst_outdata", bus.io_out_data, 32'd0);
      rst = 1'b0;

      // ALU pass-through
      set_op(5'd3, 1'b1, 32'h1234, 32'h0);
      #1 chk("alu_stall", {31'd0, bus.stall_req}, 32'd0);
      tick();
      chk("alu_wdata", bus.wdata_o, 32'h1234);
      chk("alu_wd", {27'd0, bus.wd_o}, 32'd3);
      chk("alu_wreg", {31'd0, bus.wreg_o}, 32'd1);

      // Stores to 0x10 and 0x0
      set_op(5'd0, 1'b0, 32'hDEADBEEF, 32'h10);
      bus.memW_i = 1'b1;
      #1 chk("st_stall", {31'd0, bus.stall_req}, 32'd0);
      tick();
      chk("st_err", {31'd0, bus.addr_err}, 32'd0);
      chk("st_wdata", bus.wdata_o, 32'hDEADBEEF);
      set_op(5'd0, 1'b0, 32'hCAFE0000, 32'h0);
      tick();

      // Load 0x10 right after the store: two cycles, one stall
      clear_req();
      set_op(5'd5, 1'b1, 32'h0, 32'h10);
      bus.memR_i = 1'b1;
      #1 chk("ld_stall_issue", {31'd0, bus.stall_req}, 32'd1);
      tick();
      chk("ld_bubble", {31'd0, bus.wreg_o}, 32'd0);
      chk("ld_stall_load", {31'd0, bus.stall_req}, 32'd0);
      tick();
      clear_req();
      chk("ld_wdata", bus.wdata_o, 32'hDEADBEEF);
      chk("ld_wd", {27'd0, bus.wd_o}, 32'd5);
      chk("ld_wreg", {31'd0, bus.wreg_o}, 32'd1);

      // Misaligned store 0x13 (same word as 0x10) and out-of-range 0x1000 (aliases word 0)
      set_op(5'd7, 1'b1, 32'h11111111, 32'h13);
      bus.memW_i = 1'b1;
      #1 chk("bad1_stall", {31'd0, bus.stall_req}, 32'd0);
      tick();
      chk("bad1_err", {31'd0, bus.addr_err}, 32'd1);
      chk("bad1_wreg", {31'd0, bus.wreg_o}, 32'd0);
      chk("bad1_wdata", bus.wdata_o, 32'd0);
      clear_req();
      tick();
      chk("bad1_pulse", {31'd0, bus.addr_err}, 32'd0);
      set_op(5'd7, 1'b1, 32'h22222222, 32'h1000);
      bus.memW_i = 1'b1;
      tick();
      chk("bad2_err", {31'd0, bus.addr_err}, 32'd1);
      chk("bad2_wreg", {31'd0, bus.wreg_o}, 32'd0);
      clear_req();
      tick();
      chk("bad2_pulse", {31'd0, bus.addr_err}, 32'd0);

      // Readbacks show the RAM untouched
      set_op(5'd8, 1'b1, 32'h0, 32'h10);
      bus.memR_i = 1'b1;
      tick(); tick();
      clear_req();
      chk("rb10_wdata", bus.wdata_o, 32'hDEADBEEF);
      set_op(5'd9, 1'b1, 32'h0, 32'h0);
      bus.memR_i = 1'b1;
      tick(); tick();
      clear_req();
      chk("rb0_wdata", bus.wdata_o, 32'hCAFE0000);
      chk("rb0_wd", {27'd0, bus.wd_o}, 32'd9);

      // Port input, valid delayed three IN_WAIT cycles
      set_op(5'd4, 1'b1, 32'h0, 32'h0);
      bus.io_in_data = 32'hA5;
      bus.in_i = 1'b1;
      #1 chk("in_stall_issue", {31'd0, bus.stall_req}, 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("in_rdy_w%0d", i), {31'd0, bus.io_in_ready}, 32'd1);
         chk($sformatf("in_stall_w%0d", i), {31'd0, bus.stall_req}, 32'd1);
         chk($sformatf("in_bubble_w%0d", i), {31'd0, bus.wreg_o}, 32'd0);
         tick();
      end
      bus.io_in_valid = 1'b1;
      #1 chk("in_rdy_hs", {31'd0, bus.io_in_ready}, 32'd1);
      chk("in_stall_hs", {31'd0, bus.stall_req}, 32'd0);
      tick();
      clear_req();
      bus.io_in_valid = 1'b0;
      chk("in_wdata", bus.wdata_o, 32'hA5);
      chk("in_wd", {27'd0, bus.wd_o}, 32'd4);
      chk("in_wreg", {31'd0, bus.wreg_o}, 32'd1);
      chk("in_rdy_drop", {31'd0, bus.io_in_ready}, 32'd0);

      // Port output, ready low for two OUT_WAIT cycles
      set_op(5'd6, 1'b1, 32'h77, 32'h0);
      bus.out_i = 1'b1;
      bus.io_out_ready = 1'b0;
      #1 chk("out_stall_issue", {31'd0, bus.stall_req}, 32'd1);
      tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("out_vld_w%0d", i), {31'd0, bus.io_out_valid}, 32'd1);
         chk($sformatf("out_data_w%0d", i), bus.io_out_data, 32'h77);
         chk($sformatf("out_stall_w%0d", i), {31'd0, bus.stall_req}, 32'd1);
         tick();
      end
      bus.io_out_ready = 1'b1;
      #1 chk("out_vld_hs", {31'd0, bus.io_out_valid}, 32'd1);
      chk("out_data_hs", bus.io_out_data, 32'h77);
      chk("out_stall_hs", {31'd0, bus.stall_req}, 32'd0);
      tick();
      clear_req();
      bus.io_out_ready = 1'b0;
      chk("out_vld_drop", {31'd0, bus.io_out_valid}, 32'd0);
      chk("out_wdata", bus.wdata_o, 32'h77);
      chk("out_wd", {27'd0, bus.wd_o}, 32'd6);
      chk("out_wreg", {31'd0, bus.wreg_o}, 32'd1);

      // Reset while waiting in OUT_WAIT
      set_op(5'd1, 1'b1, 32'h99, 32'h0);
      bus.out_i = 1'b1;
      tick();
      clear_req();
      chk("rstow_vld_pre", {31'd0, bus.io_out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstow_vld", {31'd0, bus.io_out_valid}, 32'd0);
      chk("rstow_data", bus.io_out_data, 32'd0);
      chk("rstow_wdata", bus.wdata_o, 32'd0);
      chk("rstow_wreg", {31'd0, bus.wreg_o}, 32'd0);
      chk("rstow_wd", {27'd0, bus.wd_o}, 32'd0);
      set_op(5'd2, 1'b1, 32'hABCD, 32'h0);
      #1 chk("rstow_stall", {31'd0, bus.stall_req}, 32'd0);
      tick();
      chk("post_rst_wdata", bus.wdata_o, 32'hABCD);
      chk("post_rst_wd", {27'd0, bus.wd_o}, 32'd2);
      chk("post_rst_wreg", {31'd0, bus.wreg_o}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
